// File: rtl/i2s_pkg.sv
// Shared constants and FSM state type for the I2S transmitter.
package i2s_pkg;
  localparam int SAMPLE_W   = 24;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/sample_edge_det.sv
// Two-flop synchronizer for the sample-rate strobe plus a registered
// rising-edge pulse; the pulse is one clk wide, two clk after the first sampling flop.
module sample_edge_det
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;
endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: 64-bit frames, 24-bit word sent in both slots.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified slots instead of I2S one-bit delay.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SCLK_DIV = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_clk,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                mute,
  output logic                sclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun,
  output logic                overrun
);
  localparam int DIV_W  = 8;
  localparam int BIT_W  = $clog2(FRAME_BITS);
  localparam int SLOT_IW = $clog2(SLOT_W);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                pending_q, pending_d;
  logic                sclk_q, sclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;
  logic                rise;
  logic                frame_start;
  logic                bit_start;

  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] w,
                                    input logic [SLOT_IW-1:0] k);
`ifdef I2S_LEFT_JUSTIFIED_EN
    if (k < 5'd24) return w[5'd23 - k];
    return 1'b0;
`else
    if (k >= 5'd1 && k <= 5'd24) return w[5'd24 - k];
    return 1'b0;
`endif
  endfunction

  sample_edge_det u_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sample_clk),
    .rise   (rise)
  );

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    pending_d   = pending_q;
    sclk_d      = sclk_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;
    overrun_d   = overrun_q;
    frame_start = 1'b0;
    bit_start   = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        if (pending_q) begin
          state_d     = RUN;
          frame_start = 1'b1;
          bit_start   = 1'b1;
        end
      end
      RUN: begin
        if (div_q == DIV_W'(SCLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d    = 1'b0;
            bit_d     = bit_q + 1'b1;
            bit_start = 1'b1;
            if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
              frame_start = 1'b1;
              underrun_d  = ~pending_q;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase

    // Copy uses the old hold value; a coincident new sample only re-arms pending.
    if (frame_start) begin
      shift_d   = mute ? '0 : hold_q;
      pending_d = 1'b0;
    end
    if (rise) begin
      hold_d    = sample_in;
      pending_d = 1'b1;
      if (pending_q && !frame_start) overrun_d = 1'b1;
    end

    if (bit_start) begin
      lrclk_d = bit_d[BIT_W-1];
      sdata_d = slot_bit(shift_d, bit_d[BIT_W-2:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      hold_q     <= '0;
      shift_q    <= '0;
      pending_q  <= 1'b0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      pending_q  <= pending_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sclk     = sclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 8: clk cycles per sclk half-period; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port sample_clk, input, 1: sample-rate strobe from the sample-rate generator; each rising edge marks a new mixed sample.
REQ-005 SHALL have port sample_in, input, 24: signed two's-complement mixed sample, valid at each sample_clk rising edge.
REQ-006 SHALL have port mute, input, 1: forces zero audio from the next frame start.
REQ-007 SHALL have port sclk, output, 1: I2S bit clock.
REQ-008 SHALL have port lrclk, output, 1: I2S word select; 0 = left slot, 1 = right slot.
REQ-009 SHALL have port sdata, output, 1: serial data, MSB first.
REQ-010 SHALL have port underrun, output, 1: one-clk pulse when a frame starts with no new sample.
REQ-011 SHALL have port overrun, output, 1: sticky flag, set when a pending sample is overwritten.

Function
REQ-012 SHALL pass sample_clk through a 2-flop synchronizer plus edge detector; a rising edge SHALL latch sample_in into the hold register 3 clk cycles after the edge, and SHALL set pending.
REQ-013 SHALL implement FSM IDLE -> RUN: IDLE after reset; leave IDLE on the clk after pending first sets; RUN is left only by reset.
REQ-014 Frame SHALL be 64 sclk periods, i.e. 128*SCLK_DIV clk: bits 0..31 left (lrclk=0), bits 32..63 right (lrclk=1); sclk is 0 in the first half of each bit and 1 in the second half.
REQ-015 At each frame start, the hold register SHALL be copied to the shift register and pending cleared; if mute=1, zero SHALL be loaded instead.
REQ-016 Mono output: the same 24-bit value SHALL be sent in the left and right slots.
REQ-017 Default (I2S) alignment: slot bit k SHALL carry word[24-k] for k=1..24, and 0 for k=0 and k=25..31.
REQ-018 sdata and lrclk SHALL change only on sclk falling edges, i.e. on bit-slot starts.
REQ-019 If pending=0 at a frame start in RUN, the previous word SHALL be resent and underrun pulsed for exactly 1 clk.
REQ-020 If a new edge arrives while pending=1, the hold register SHALL take the newer sample and overrun SHALL set; overrun clears only on reset.
REQ-021 If an edge and a frame-start copy fall on the same clk, the copy SHALL take the old hold value, and the new sample SHALL set pending with no overrun.
REQ-022 Bit and divider counters SHALL wrap 63 -> 0 and SCLK_DIV-1 -> 0 with no idle gap between frames.
REQ-023 In IDLE: sclk=0, lrclk=0, sdata=0.

Reset
REQ-024 Reset SHALL force sclk=0, lrclk=0, sdata=0, underrun=0, overrun=0, pending=0, hold register=0, shift register=0, all counters=0, state=IDLE.
REQ-025 Reset asserted mid-frame SHALL abandon the frame immediately; output SHALL resume only after a post-reset sample edge.

Configuration
REQ-026 Macro I2S_LEFT_JUSTIFIED_EN: if defined, slot bit k SHALL carry word[23-k] for k=0..23 and 0 for k=24..31 (MSB aligned with the lrclk transition); if undefined, REQ-017 alignment SHALL apply.

Structure
REQ-027 Package i2s_pkg SHALL hold SAMPLE_W=24, SLOT_W=32, FRAME_BITS=64 and the FSM state enum (IDLE, RUN).
REQ-028 Sub-module sample_edge_det SHALL implement the synchronizer and rising-edge detector; all other logic SHALL be in i2s_tx.

Verification
REQ-029 Reset, then one edge with sample_in=24'hA5F00F, SCLK_DIV=8 -> RUN starts 4 clk after the edge; left slot bits 1..24 = A5F00F MSB first; right slot identical; frame length 1024 clk.
REQ-030 Build with I2S_LEFT_JUSTIFIED_EN, sample 24'h800001 -> bit 0 of each slot = 1, bit 23 = 1, bits 1..22 and 24..31 = 0.
REQ-031 Stop edges after the first sample -> underrun pulses 1 clk at each later frame start; 24'hA5F00F repeated.
REQ-032 Two edges 10 clk apart within one frame (24'h111111 then 24'h222222) -> next frame sends 222222; overrun=1 and stays 1.
REQ-033 mute=1 with sample 24'h7FFFFF -> next frame all-zero sdata; mute=0 -> following frame 7FFFFF.
REQ-034 Reset asserted at frame bit 40 -> next clk all outputs 0 and state IDLE; no sclk toggles until a new edge.
